mbist_pat_gen: RTL and testbench
================================

# mbist_pat_gen

MBIST march-element stimulus generator: on `start` it walks the BIST address range, issuing one or two read/write operations per address to the memory under test. For every read it emits the matching expected data, `read_invert` and address to the data comparator, aligned to the memory read latency. It sits between the MBIST controller FSM (which sequences march elements) and the memory port / comparator pair.

## Interface
- `BIST_ADDR_WD`, 9: address width
- `BIST_DATA_WD`, 32: data width
- `BIST_ADDR_START`, 9'h000: first address of range
- `BIST_ADDR_END`, 9'h1F8: last address of range (inclusive, >= START)
- `BIST_RD_LAT`, 1: memory read latency in cycles, legal 1..3
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `start` in 1: pulse; begin element (ignored unless idle)
- `pause` in 1: hold sequencing, no issue this cycle
- `addr_dir` in 1: 0 ascending, 1 descending
- `op0` in 2: {is_write, invert} for first op per address
- `op1_en` in 1: second op per address enabled
- `op1` in 2: {is_write, invert} for second op
- `pattern` in BIST_DATA_WD: background data
- `mem_cs` out 1: memory select
- `mem_we` out 1: 1 write, 0 read (valid with mem_cs)
- `mem_addr` out BIST_ADDR_WD: memory address
- `mem_wdata` out BIST_DATA_WD: write data
- `compare` out 1: comparator strobe
- `read_invert` out 1: invert flag of the read being checked
- `comp_data` out BIST_DATA_WD: uninverted background for comparison
- `cmp_addr` out BIST_ADDR_WD: address of the read being checked
- `busy` out 1: element in progress
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, OP0, OP1, DRAIN, DONE. `op0/op1/op1_en/addr_dir/pattern` sampled into registers on accepted `start`; held stable for the element.
- IDLE: `start` -> OP0, addr reg = START (asc) or END (desc), drain count = 0.
- OP0: if `pause`, hold. Else issue op0; if op1 enabled -> OP1 (same addr); else if last address -> DRAIN; else step address (+1 asc, -1 desc), stay OP0.
- OP1: if `pause`, hold. Else issue op1; last address -> DRAIN, else step address -> OP0.
- Last address: END ascending, START descending. No wrap-around ever issued.
- DRAIN: count BIST_RD_LAT cycles, then DONE. `pause` ignored.
- DONE: `done`=1 for one cycle -> IDLE.
- Issue (combinational from state regs): `mem_cs`=1, `mem_we`=is_write, `mem_addr`=addr reg, `mem_wdata`= invert ? ~pattern : pattern. Not issuing: `mem_cs`=0, `mem_we`=0, addr/wdata hold last value.
- Read check pipeline: shift register depth BIST_RD_LAT carrying {valid, invert, addr}; shifts every cycle regardless of `pause`/state.
- `busy` = state != IDLE. `start` while busy ignored.

## Timing
- Reset: all state/pipeline cleared; state IDLE; every output 0.
- `start` sampled at edge 0 -> `mem_cs` high in cycle 1.
- Read issued in cycle t -> `compare`=1 in cycle t+BIST_RD_LAT with `comp_data`=pattern, `read_invert`=op invert, `cmp_addr`=issue address. Writes never raise `compare`.
- Unpaused element length: N*k issue cycles (N = END-START+1, k = 1 or 2) + BIST_RD_LAT drain + 1 done cycle.
- `pause` high in cycle t: no issue in t; sequencing resumes the cycle `pause` drops; in-flight compares still emerge on time.
- `rst` mid-element: next edge returns to IDLE, pipeline flushed; no `compare` or `done` afterwards.
- `start` coincident with DONE: ignored.

## Configuration
- `MBIST_ADDR_DOWN_EN` defined: `addr_dir` honoured, descending walk supported.
- Undefined: `addr_dir` port present but ignored; always ascending from START to END; no decrement logic.

## Test plan
- START=0, END=3, RD_LAT=1, op0={1,0}, op1_en=0, pattern=32'hA5A5A5A5: writes to 0..3 in cycles 1..4 with wdata A5A5A5A5, no `compare`, `done` in cycle 6.
- Same range, op0={0,1}, op1={1,0}, op1_en=1, pattern=32'h0F0F0F0F: alternating read/write per address, `compare` cycles 2,4,6,8 with `read_invert`=1, `comp_data`=0F0F0F0F, `cmp_addr`=0..3; `done` cycle 10.
- RD_LAT=3, read-only element, `pause` high cycles 2-3: issue at 1,4,5,6; `compare` at 4,7,8,9; `done` cycle 10.
- With `MBIST_ADDR_DOWN_EN`, addr_dir=1: `mem_addr` sequence 3,2,1,0, no wrap past 0; without macro same stimulus gives 0,1,2,3.
- `rst` asserted cycle 3 of a read element: state IDLE, all outputs 0 from cycle 4, no later `compare`/`done`; `start` during busy produces no restart.

Source files
------------

// File: rtl/mbist_pat_gen.sv
// mbist_pat_gen
//   MBIST march-element stimulus generator. On start it walks the address
//   range START..END and issues one or two operations (op0, optional op1)
//   per address to the memory under test. Each read issued here reappears
//   BIST_RD_LAT cycles later on the comparator side as a compare strobe,
//   together with the background data, the read's invert flag and its address.
//
//   Optional feature macro: MBIST_ADDR_DOWN_EN
//     defined   - addr_dir selects an ascending (0) or descending (1) walk
//     undefined - addr_dir is ignored and the walk is always ascending
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin an element (taken only when idle)
//   pause             suppress issue and hold sequencing for this cycle
//   addr_dir          walk direction (see macro above)
//   op0, op1          {is_write, invert} of the first / second op per address
//   op1_en            enable the second op per address
//   pattern           background data
//   mem_cs/mem_we/mem_addr/mem_wdata   memory port
//   compare/read_invert/comp_data/cmp_addr   comparator side
//   busy              element in progress
//   done              one-cycle completion pulse
module mbist_pat_gen #(
  parameter int                      BIST_ADDR_WD    = 9,
  parameter int                      BIST_DATA_WD    = 32,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8,
  parameter int                      BIST_RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    addr_dir,
  input  logic [1:0]              op0,
  input  logic                    op1_en,
  input  logic [1:0]              op1,
  input  logic [BIST_DATA_WD-1:0] pattern,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic [BIST_ADDR_WD-1:0] mem_addr,
  output logic [BIST_DATA_WD-1:0] mem_wdata,
  output logic                    compare,
  output logic                    read_invert,
  output logic [BIST_DATA_WD-1:0] comp_data,
  output logic [BIST_ADDR_WD-1:0] cmp_addr,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OP0   = 3'd1,
    S_OP1   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [BIST_ADDR_WD-1:0] addr_q, addr_d;
  logic [1:0]              op0_q, op0_d;
  logic [1:0]              op1_q, op1_d;
  logic                    op1_en_q, op1_en_d;
  logic [BIST_DATA_WD-1:0] pattern_q, pattern_d;
  logic [BIST_DATA_WD-1:0] wdata_q, wdata_d;
  logic [1:0]              drain_q, drain_d;

  // Read-check pipeline, one entry per cycle of memory read latency.
  logic                    rd_vld_q  [BIST_RD_LAT];
  logic                    rd_inv_q  [BIST_RD_LAT];
  logic [BIST_ADDR_WD-1:0] rd_addr_q [BIST_RD_LAT];

  logic                    issue;
  logic [1:0]              cur_op;
  logic [BIST_DATA_WD-1:0] issue_wdata;
  logic                    last_addr;
  logic [BIST_ADDR_WD-1:0] next_addr;
  logic [BIST_ADDR_WD-1:0] first_addr;

`ifdef MBIST_ADDR_DOWN_EN
  logic dir_q, dir_d;

  assign first_addr = addr_dir ? BIST_ADDR_END : BIST_ADDR_START;
  assign last_addr  = dir_q ? (addr_q == BIST_ADDR_START) : (addr_q == BIST_ADDR_END);
  assign next_addr  = dir_q ? (addr_q - BIST_ADDR_WD'(1)) : (addr_q + BIST_ADDR_WD'(1));
`else
  logic unused_addr_dir;

  assign unused_addr_dir = addr_dir;
  assign first_addr      = BIST_ADDR_START;
  assign last_addr       = (addr_q == BIST_ADDR_END);
  assign next_addr       = addr_q + BIST_ADDR_WD'(1);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op0_d     = op0_q;
    op1_d     = op1_q;
    op1_en_d  = op1_en_q;
    pattern_d = pattern_q;
    drain_d   = drain_q;
    issue     = 1'b0;
    cur_op    = op0_q;
`ifdef MBIST_ADDR_DOWN_EN
    dir_d     = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_OP0;
          addr_d    = first_addr;
          op0_d     = op0;
          op1_d     = op1;
          op1_en_d  = op1_en;
          pattern_d = pattern;
          drain_d   = 2'd0;
`ifdef MBIST_ADDR_DOWN_EN
          dir_d     = addr_dir;
`endif
        end
      end
      S_OP0: begin
        cur_op = op0_q;
        if (!pause) begin
          issue = 1'b1;
          if (op1_en_q) begin
            state_d = S_OP1;
          end else if (last_addr) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = next_addr;
          end
        end
      end
      S_OP1: begin
        cur_op = op1_q;
        if (!pause) begin
          issue = 1'b1;
          if (last_addr) begin
            state_d = S_DRAIN;
          end else begin
            addr_d  = next_addr;
            state_d = S_OP0;
          end
        end
      end
      // Let the final read of the element reach the comparator before done.
      S_DRAIN: begin
        if (drain_q == 2'(BIST_RD_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign issue_wdata = cur_op[0] ? ~pattern_q : pattern_q;
  // Write data is remembered so the port holds its last value between issues.
  assign wdata_d     = issue ? issue_wdata : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      op0_q     <= '0;
      op1_q     <= '0;
      op1_en_q  <= 1'b0;
      pattern_q <= '0;
      wdata_q   <= '0;
      drain_q   <= '0;
`ifdef MBIST_ADDR_DOWN_EN
      dir_q     <= 1'b0;
`endif
      for (int i = 0; i < BIST_RD_LAT; i++) begin
        rd_vld_q[i]  <= 1'b0;
        rd_inv_q[i]  <= 1'b0;
        rd_addr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op0_q     <= op0_d;
      op1_q     <= op1_d;
      op1_en_q  <= op1_en_d;
      pattern_q <= pattern_d;
      wdata_q   <= wdata_d;
      drain_q   <= drain_d;
`ifdef MBIST_ADDR_DOWN_EN
      dir_q     <= dir_d;
`endif
      // Pipeline shifts unconditionally so compares emerge on time under pause.
      rd_vld_q[0]  <= issue & ~cur_op[1];
      rd_inv_q[0]  <= cur_op[0];
      rd_addr_q[0] <= addr_q;
      for (int i = 1; i < BIST_RD_LAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_inv_q[i]  <= rd_inv_q[i-1];
        rd_addr_q[i] <= rd_addr_q[i-1];
      end
    end
  end

  assign mem_cs    = issue;
  assign mem_we    = issue & cur_op[1];
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_d;

  assign compare     = rd_vld_q[BIST_RD_LAT-1];
  assign read_invert = compare & rd_inv_q[BIST_RD_LAT-1];
  assign cmp_addr    = compare ? rd_addr_q[BIST_RD_LAT-1] : '0;
  assign comp_data   = compare ? pattern_q : '0;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mbist_pat_gen.sv
module tb_mbist_pat_gen;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start1, start3, pause, addr_dir, op1_en;
  logic [1:0]    op0, op1;
  logic [DW-1:0] pattern;

  logic          cs1, we1, cmp1, inv1, busy1, done1;
  logic [AW-1:0] addr1, caddr1;
  logic [DW-1:0] wd1, cdata1;
  logic          cs3, we3, cmp3, inv3, busy3, done3;
  logic [AW-1:0] addr3, caddr3;
  logic [DW-1:0] wd3, cdata3;

  mbist_pat_gen #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_ADDR_START(9'd0),
                  .BIST_ADDR_END(9'd3), .BIST_RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pause(pause), .addr_dir(addr_dir),
    .op0(op0), .op1_en(op1_en), .op1(op1), .pattern(pattern),
    .mem_cs(cs1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .compare(cmp1), .read_invert(inv1), .comp_data(cdata1), .cmp_addr(caddr1),
    .busy(busy1), .done(done1));

  mbist_pat_gen #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_ADDR_START(9'd0),
                  .BIST_ADDR_END(9'd3), .BIST_RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .pause(pause), .addr_dir(addr_dir),
    .op0(op0), .op1_en(op1_en), .op1(op1), .pattern(pattern),
    .mem_cs(cs3), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wd3),
    .compare(cmp3), .read_invert(inv3), .comp_data(cdata3), .cmp_addr(caddr3),
    .busy(busy3), .done(done3));

  // Observed outputs of whichever instance the current element targets.
  bit            sel3 = 1'b0;
  logic          o_cs, o_we, o_cmp, o_inv, o_busy, o_done;
  logic [AW-1:0] o_addr, o_caddr;
  logic [DW-1:0] o_wd, o_cdata;

  always_comb begin
    if (sel3) begin
      o_cs = cs3; o_we = we3; o_addr = addr3; o_wd = wd3; o_cmp = cmp3;
      o_inv = inv3; o_cdata = cdata3; o_caddr = caddr3; o_busy = busy3; o_done = done3;
    end else begin
      o_cs = cs1; o_we = we1; o_addr = addr1; o_wd = wd1; o_cmp = cmp1;
      o_inv = inv1; o_cdata = cdata1; o_caddr = caddr1; o_busy = busy1; o_done = done1;
    end
  end

  typedef struct {
    int            cyc;
    logic          inv;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmp_t;

  cmp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Runs one element on the LAT=1 or LAT=3 instance (range 0..3).
  // Pause is held over cycles plo..phi; rst_c >= 0 asserts rst in that cycle;
  // restart_c >= 1 pulses start again in that cycle (must be ignored).
  task automatic run(input int lat, input logic [1:0] p_op0, input logic p_op1en,
                     input logic [1:0] p_op1, input logic [DW-1:0] pat, input logic dir,
                     input int plo, input int phi, input int rst_c, input int restart_c);
    bit            e_cs [64];
    bit            e_we [64];
    logic [AW-1:0] e_addr [64];
    logic [DW-1:0] e_wd [64];
    int            c, done_c, last_c;
    logic [AW-1:0] a;
    logic [1:0]    op;
    bit            eff_dir;
    cmp_t          got;

`ifdef MBIST_ADDR_DOWN_EN
    eff_dir = dir;
`else
    eff_dir = 1'b0;
`endif
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e_cs[i] = 1'b0; e_we[i] = 1'b0; e_addr[i] = '0; e_wd[i] = '0;
    end
    c = 1;
    for (int i = 0; i < 4; i++) begin
      a = eff_dir ? AW'(3 - i) : AW'(i);
      for (int k = 0; k < (p_op1en ? 2 : 1); k++) begin
        op = (k == 1) ? p_op1 : p_op0;
        while (c >= plo && c <= phi) c++;
        e_cs[c] = 1'b1; e_we[c] = op[1]; e_addr[c] = a;
        e_wd[c] = op[0] ? ~pat : pat;
        if (!op[1] && (rst_c < 0 || c + lat <= rst_c))
          sb.push_back('{cyc: c + lat, inv: op[0], addr: a, data: pat});
        c++;
      end
    end
    done_c = c + lat;
    if (rst_c >= 0) begin
      for (int i = rst_c + 1; i < 64; i++) e_cs[i] = 1'b0;
      done_c = -1;
    end
    last_c = (rst_c >= 0) ? rst_c + 5 : done_c + 2;
    sel3 = (lat == 3);

    for (int cyc = 0; cyc <= last_c; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        op0 = p_op0; op1 = p_op1; op1_en = p_op1en; pattern = pat; addr_dir = dir;
      end else begin
        // Scramble inputs: the element must run from its captured copies.
        op0 = ~p_op0; op1 = ~p_op1; op1_en = ~p_op1en; pattern = ~pat; addr_dir = ~dir;
      end
      start1 = !sel3 && (cyc == 0 || cyc == restart_c);
      start3 =  sel3 && (cyc == 0 || cyc == restart_c);
      pause  = (cyc >= plo && cyc <= phi);
      rst    = (cyc == rst_c);
      #1;
      if (cyc >= 1) begin
        chk($sformatf("cs@%0d", cyc), o_cs, e_cs[cyc]);
        if (e_cs[cyc]) begin
          chk($sformatf("we@%0d", cyc), o_we, e_we[cyc]);
          chk($sformatf("addr@%0d", cyc), o_addr, e_addr[cyc]);
          chk($sformatf("wdata@%0d", cyc), o_wd, e_wd[cyc]);
        end
        chk($sformatf("busy@%0d", cyc), o_busy,
            (rst_c >= 0) ? (cyc <= rst_c) : (cyc <= done_c));
        chk($sformatf("done@%0d", cyc), o_done, cyc == done_c);
        if (o_cmp) begin
          if (sb.size() == 0) begin
            chk($sformatf("cmp_extra@%0d", cyc), 1'b1, 1'b0);
          end else begin
            got = sb.pop_front();
            chk($sformatf("cmp_cyc@%0d", cyc), cyc, got.cyc);
            chk($sformatf("cmp_inv@%0d", cyc), o_inv, got.inv);
            chk($sformatf("cmp_addr@%0d", cyc), o_caddr, got.addr);
            chk($sformatf("cmp_data@%0d", cyc), o_cdata, got.data);
          end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          got = sb.pop_front();
          chk($sformatf("cmp_miss@%0d", cyc), 1'b0, 1'b1);
        end
        if (rst_c >= 0 && cyc == rst_c + 1)
          chk("rst_outs_zero",
              |{o_cs, o_we, o_addr, o_wd, o_cmp, o_inv, o_cdata, o_caddr, o_busy, o_done},
              1'b0);
      end
    end
    start1 = 1'b0; start3 = 1'b0; pause = 1'b0; rst = 1'b0;
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; pause = 1'b0; addr_dir = 1'b0;
    op0 = 2'b00; op1 = 2'b00; op1_en = 1'b0; pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dut1",
        |{cs1, we1, addr1, wd1, cmp1, inv1, cdata1, caddr1, busy1, done1}, 1'b0);
    chk("reset_dut3",
        |{cs3, we3, addr3, wd3, cmp3, inv3, cdata3, caddr3, busy3, done3}, 1'b0);
    rst = 1'b0;

    // Write-only walk; start coincident with done must be ignored.
    run(1, 2'b10, 1'b0, 2'b00, 32'hA5A5A5A5, 1'b0, 100, 0, -1, 6);
    // Inverted read then write per address.
    run(1, 2'b01, 1'b1, 2'b10, 32'h0F0F0F0F, 1'b0, 100, 0, -1, -1);
    // RD_LAT=3 read-only with pause in cycles 2-3, start while busy in cycle 5.
    run(3, 2'b00, 1'b0, 2'b00, 32'h12345678, 1'b0, 2, 3, -1, 5);
    // Descending request (ascending when the feature is not built).
    run(1, 2'b10, 1'b0, 2'b00, 32'hC3C3C3C3, 1'b1, 100, 0, -1, -1);
    // Reset in cycle 3 of a read element.
    run(1, 2'b00, 1'b0, 2'b00, 32'hDEADBEEF, 1'b0, 100, 0, 3, -1);
    // Reset on LAT=3 with reads still in flight.
    run(3, 2'b01, 1'b0, 2'b00, 32'h5A5AF00F, 1'b0, 100, 0, 5, -1);
    // Write-invert then read, descending request, pause mid-element on LAT=3.
    run(3, 2'b11, 1'b1, 2'b00, 32'h89ABCDEF, 1'b1, 5, 6, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
